// File: rtl/accumulator_sequencer_pkg.sv
// Shared types and sizing for the accumulator sequencer: vector geometry,
// default counter widths and the 3-bit binary FSM encoding.
package accumulator_sequencer_pkg;

   localparam int ARRAY_COL      = 16;
   localparam int ACC_WIDTH      = 32;
   localparam int VW             = ARRAY_COL * ACC_WIDTH;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int KT_WIDTH_DEF   = 8;

   typedef enum logic [2:0] {
      ACC_SEQ_IDLE       = 3'd0,
      ACC_SEQ_ACCUM      = 3'd1,
      ACC_SEQ_DRAIN_RD   = 3'd2,
      ACC_SEQ_DRAIN_HOLD = 3'd3,
      ACC_SEQ_DONE       = 3'd4
   } acc_seq_state_e;

endpackage

// File: rtl/accumulator_sequencer.sv
// Steps the accumulator bank through one output tile: K-tile accumulation of
// psum rows, then a valid/ready drain of rows 0..cfg_rows-1.
module accumulator_sequencer
   import accumulator_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int KT_WIDTH   = KT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   cfg_rows,
   input  logic [KT_WIDTH-1:0]   cfg_ktiles,
   input  logic                  psum_valid,
   input  logic [VW-1:0]         psum_vec,
   output logic [ADDR_WIDTH-1:0] bank_addr,
   output logic                  bank_wr_en,
   output logic                  bank_acc_mode,
   output logic [VW-1:0]         bank_psum_vec,
   input  logic [VW-1:0]         bank_acc_vec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [VW-1:0]         out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err_psum
);

   localparam logic [ADDR_WIDTH:0] ROW_ONE = 1;
   localparam logic [KT_WIDTH-1:0] KT_ONE  = 1;

   acc_seq_state_e state_q, state_d;

   logic [ADDR_WIDTH:0]   row_q, rows_cfg_q;
   logic [KT_WIDTH-1:0]   kt_q, kt_cfg_q;
   logic                  fin_q, wr_en_q, acc_mode_q, held_q, err_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [VW-1:0]         psum_q, out_data_q;

   logic start_ok, cfg_zero, row_last, kt_last, psum_take, draining;

   assign start_ok  = start && (state_q == ACC_SEQ_IDLE);
   assign cfg_zero  = (cfg_rows == '0) || (cfg_ktiles == '0);
   assign row_last  = (row_q == rows_cfg_q - ROW_ONE);
   assign kt_last   = (kt_q == kt_cfg_q - KT_ONE);
   // fin_q marks the cycle in which the final write is on the bank port.
   assign psum_take = (state_q == ACC_SEQ_ACCUM) && psum_valid && !fin_q;
   assign draining  = (state_q == ACC_SEQ_DRAIN_RD) || (state_q == ACC_SEQ_DRAIN_HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACC_SEQ_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC_SEQ_IDLE:       if (start) state_d = cfg_zero ? ACC_SEQ_DONE : ACC_SEQ_ACCUM;
         ACC_SEQ_ACCUM:      if (fin_q) state_d = ACC_SEQ_DRAIN_RD;
         ACC_SEQ_DRAIN_RD:   state_d = ACC_SEQ_DRAIN_HOLD;
         ACC_SEQ_DRAIN_HOLD: if (out_ready) state_d = row_last ? ACC_SEQ_DONE : ACC_SEQ_DRAIN_RD;
         ACC_SEQ_DONE:       state_d = ACC_SEQ_IDLE;
         default:            state_d = ACC_SEQ_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; wide data
   // registers are reset too so every output reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q      <= '0;
         rows_cfg_q <= '0;
         kt_q       <= '0;
         kt_cfg_q   <= '0;
         fin_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         acc_mode_q <= 1'b0;
         wr_addr_q  <= '0;
         psum_q     <= '0;
         held_q     <= 1'b0;
         out_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_en_q <= psum_take;
         if (start_ok && !cfg_zero) begin
            rows_cfg_q <= cfg_rows;
            kt_cfg_q   <= cfg_ktiles;
            row_q      <= '0;
            kt_q       <= '0;
            fin_q      <= 1'b0;
         end
         if (psum_take) begin
            wr_addr_q  <= row_q[ADDR_WIDTH-1:0];
            acc_mode_q <= (kt_q != '0);
            psum_q     <= psum_vec;
            if (row_last) begin
               row_q <= '0;
               kt_q  <= kt_q + KT_ONE;
               if (kt_last) fin_q <= 1'b1;
            end else begin
               row_q <= row_q + ROW_ONE;
            end
         end
         if ((state_q == ACC_SEQ_ACCUM) && fin_q) fin_q <= 1'b0;
         // The first hold cycle sees fresh bank data; later cycles replay the capture.
         if (state_q == ACC_SEQ_DRAIN_HOLD) begin
            held_q <= !out_ready;
            if (!held_q) out_data_q <= bank_acc_vec;
            if (out_ready && !row_last) row_q <= row_q + ROW_ONE;
         end else begin
            held_q <= 1'b0;
         end
         if (start_ok) err_q <= 1'b0;
         if (psum_valid && (state_q != ACC_SEQ_ACCUM)) err_q <= 1'b1;
      end
   end

   assign busy          = (state_q != ACC_SEQ_IDLE);
   assign done          = (state_q == ACC_SEQ_DONE);
   assign err_psum      = err_q;
   assign bank_addr     = draining ? row_q[ADDR_WIDTH-1:0] : wr_addr_q;
   assign bank_wr_en    = wr_en_q;
   assign bank_acc_mode = acc_mode_q;
   assign bank_psum_vec = psum_q;
   assign out_valid     = (state_q == ACC_SEQ_DRAIN_HOLD);
   assign out_last      = out_valid && row_last;
   assign out_data      = !out_valid ? '0 : (held_q ? out_data_q : bank_acc_vec);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer with a behavioural accumulator bank
// (overwrite/accumulate per column, registered read).
module tb_accumulator_sequencer;
   import accumulator_sequencer_pkg::*;

   localparam int AW = 8;
   localparam int KW = 8;

   logic          clk, rst_n, start, psum_valid, out_ready;
   logic [AW:0]   cfg_rows;
   logic [KW-1:0] cfg_ktiles;
   logic [VW-1:0] psum_vec, bank_psum_vec, bank_acc_vec, out_data;
   logic [AW-1:0] bank_addr;
   logic          bank_wr_en, bank_acc_mode, out_valid, out_last, busy, done, err_psum;

   accumulator_sequencer #(.ADDR_WIDTH(AW), .KT_WIDTH(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_ktiles(cfg_ktiles),
      .psum_valid(psum_valid), .psum_vec(psum_vec), .bank_addr(bank_addr),
      .bank_wr_en(bank_wr_en), .bank_acc_mode(bank_acc_mode), .bank_psum_vec(bank_psum_vec),
      .bank_acc_vec(bank_acc_vec), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done), .err_psum(err_psum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [VW-1:0] mem [0:255];
   logic [VW-1:0] bank_nxt;
   always @(posedge clk) begin
      bank_acc_vec <= mem[bank_addr];
      if (bank_wr_en) begin
         for (int c = 0; c < ARRAY_COL; c++)
            bank_nxt[c*ACC_WIDTH +: ACC_WIDTH] = bank_acc_mode ?
               mem[bank_addr][c*ACC_WIDTH +: ACC_WIDTH] + bank_psum_vec[c*ACC_WIDTH +: ACC_WIDTH] :
               bank_psum_vec[c*ACC_WIDTH +: ACC_WIDTH];
         mem[bank_addr] <= bank_nxt;
      end
   end

   logic [AW-1:0] wr_addr_log[$];
   logic          wr_mode_log[$];
   logic [VW-1:0] wr_vec_log[$];
   logic [VW-1:0] rd_log[$];
   logic          rd_last_log[$];
   int            done_cnt = 0;

   always @(negedge clk) begin
      if (bank_wr_en) begin
         wr_addr_log.push_back(bank_addr);
         wr_mode_log.push_back(bank_acc_mode);
         wr_vec_log.push_back(bank_psum_vec);
      end
      if (out_valid && out_ready) begin
         rd_log.push_back(out_data);
         rd_last_log.push_back(out_last);
      end
      if (done) done_cnt++;
   end

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] col0_vec(input int v);
      logic [VW-1:0] r;
      r = '0;
      r[ACC_WIDTH-1:0] = v[ACC_WIDTH-1:0];
      return r;
   endfunction

   function automatic logic [VW-1:0] ramp_vec(input int scale);
      logic [VW-1:0] r;
      int            e;
      for (int c = 0; c < ARRAY_COL; c++) begin
         e = scale * (c + 1);
         r[c*ACC_WIDTH +: ACC_WIDTH] = e[ACC_WIDTH-1:0];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_mode_log.delete();
      wr_vec_log.delete();
      rd_log.delete();
      rd_last_log.delete();
   endtask

   task automatic do_start(input logic [AW:0] rows, input logic [KW-1:0] kts);
      start = 1'b1;
      cfg_rows = rows;
      cfg_ktiles = kts;
      tick();
      start = 1'b0;
   endtask

   task automatic send_psum(input logic [VW-1:0] v);
      psum_valid = 1'b1;
      psum_vec = v;
      tick();
      psum_valid = 1'b0;
      psum_vec = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_idle_timeout"}, busy, 1'b0);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_valid_timeout"}, out_valid, 1'b1);
   endtask

   initial begin
      int d0, bad, nlast;
      logic [3:0] last4;
      logic [5:0] mode6;
      logic [1:0] last2;

      rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_ktiles = '0;
      psum_valid = 1'b0; psum_vec = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_wr_en", bank_wr_en, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_err", err_psum, 1'b0);
      check("rst_addr", bank_addr, '0);
      rst_n = 1'b1;
      tick();

      // 1: single K-tile, four rows
      clear_logs(); d0 = done_cnt;
      do_start(9'd4, 8'd1);
      for (int i = 1; i <= 4; i++) send_psum(col0_vec(i));
      wait_idle("t1");
      check("t1_wr_count", wr_addr_log.size(), 4);
      for (int i = 0; i < wr_addr_log.size(); i++) begin
         check($sformatf("t1_wr_addr%0d", i), wr_addr_log[i], i[AW-1:0]);
         check($sformatf("t1_wr_mode%0d", i), wr_mode_log[i], 1'b0);
         check($sformatf("t1_wr_vec%0d", i), wr_vec_log[i], col0_vec(i + 1));
      end
      check("t1_rd_count", rd_log.size(), 4);
      last4 = '0;
      for (int i = 0; i < rd_log.size() && i < 4; i++) begin
         check($sformatf("t1_rd%0d", i), rd_log[i], col0_vec(i + 1));
         last4[i] = rd_last_log[i];
      end
      check("t1_last", last4, 4'b1000);
      check("t1_done_count", done_cnt - d0, 1);

      // 2: three K-tiles of two rows, accumulate
      clear_logs(); d0 = done_cnt;
      do_start(9'd2, 8'd3);
      for (int i = 0; i < 6; i++) send_psum(ramp_vec(1));
      wait_idle("t2");
      check("t2_wr_count", wr_addr_log.size(), 6);
      mode6 = '0;
      for (int i = 0; i < wr_addr_log.size() && i < 6; i++) begin
         mode6[i] = wr_mode_log[i];
         check($sformatf("t2_wr_addr%0d", i), wr_addr_log[i], (i % 2));
      end
      check("t2_modes", mode6, 6'b111100);
      check("t2_rd_count", rd_log.size(), 2);
      last2 = '0;
      for (int i = 0; i < rd_log.size() && i < 2; i++) begin
         check($sformatf("t2_rd%0d", i), rd_log[i], ramp_vec(3));
         last2[i] = rd_last_log[i];
      end
      check("t2_last", last2, 2'b10);
      check("t2_done_count", done_cnt - d0, 1);

      // 3: backpressure on drained row 1
      clear_logs();
      out_ready = 1'b0;
      do_start(9'd3, 8'd1);
      send_psum(col0_vec(10));
      send_psum(col0_vec(20));
      send_psum(col0_vec(30));
      wait_valid("t3_row0");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_valid("t3_row1");
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t3_hold_valid%0d", k), out_valid, 1'b1);
         check($sformatf("t3_hold_data%0d", k), out_data, col0_vec(20));
         check($sformatf("t3_hold_addr%0d", k), bank_addr, 8'd1);
         check($sformatf("t3_hold_last%0d", k), out_last, 1'b0);
         tick();
      end
      out_ready = 1'b1;
      wait_idle("t3");
      check("t3_rd_count", rd_log.size(), 3);
      for (int i = 0; i < rd_log.size() && i < 3; i++)
         check($sformatf("t3_rd%0d", i), rd_log[i], col0_vec(10 * (i + 1)));

      // 4: full 256-row address range
      clear_logs();
      do_start(9'd256, 8'd1);
      for (int i = 0; i < 256; i++) send_psum(col0_vec(i));
      wait_idle("t4");
      check("t4_wr_count", wr_addr_log.size(), 256);
      bad = 0;
      for (int i = 0; i < wr_addr_log.size(); i++)
         if (wr_addr_log[i] !== i[AW-1:0]) bad++;
      check("t4_wr_addr_errors", bad, 0);
      check("t4_rd_count", rd_log.size(), 256);
      bad = 0; nlast = 0;
      for (int i = 0; i < rd_log.size(); i++) begin
         if (rd_log[i] !== col0_vec(i)) bad++;
         if (rd_last_log[i]) nlast++;
      end
      check("t4_rd_errors", bad, 0);
      check("t4_last_count", nlast, 1);
      if (rd_last_log.size() == 256) check("t4_last_at_255", rd_last_log[255], 1'b1);

      // 5: zero-config start and psum outside ACCUM
      clear_logs(); d0 = done_cnt;
      check("t5_err_before", err_psum, 1'b0);
      do_start(9'd3, 8'd0);
      check("t5_done_pulse", done, 1'b1);
      tick();
      check("t5_done_clear", done, 1'b0);
      check("t5_busy_clear", busy, 1'b0);
      check("t5_done_count", done_cnt - d0, 1);
      check("t5_no_writes", wr_addr_log.size(), 0);
      check("t5_no_rows", rd_log.size(), 0);
      send_psum(col0_vec(7));
      check("t5_err_set", err_psum, 1'b1);
      repeat (3) tick();
      check("t5_err_sticky", err_psum, 1'b1);
      check("t5_idle_psum_no_write", wr_addr_log.size(), 0);
      do_start(9'd1, 8'd1);
      check("t5_err_cleared", err_psum, 1'b0);
      send_psum(col0_vec(9));
      wait_idle("t5");
      check("t5_rd_count", rd_log.size(), 1);
      if (rd_log.size() == 1) check("t5_rd0", rd_log[0], col0_vec(9));

      // 6: reset in the middle of accumulation (kt=1, row=1)
      clear_logs();
      do_start(9'd2, 8'd2);
      send_psum(col0_vec(1));
      send_psum(col0_vec(2));
      send_psum(col0_vec(3));
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("t6_busy", busy, 1'b0);
      check("t6_wr_en", bank_wr_en, 1'b0);
      check("t6_addr", bank_addr, '0);
      check("t6_acc_mode", bank_acc_mode, 1'b0);
      check("t6_psum_vec", bank_psum_vec, '0);
      check("t6_out_valid", out_valid, 1'b0);
      check("t6_out_last", out_last, 1'b0);
      check("t6_out_data", out_data, '0);
      check("t6_done", done, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("t6_no_done", done_cnt - d0, 0);
      clear_logs(); d0 = done_cnt;
      do_start(9'd2, 8'd1);
      send_psum(col0_vec(5));
      send_psum(col0_vec(6));
      wait_idle("t6");
      check("t6_rd_count", rd_log.size(), 2);
      for (int i = 0; i < rd_log.size() && i < 2; i++)
         check($sformatf("t6_rd%0d", i), rd_log[i], col0_vec(5 + i));
      check("t6_done_count", done_cnt - d0, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
